button_conditioner: RTL
=======================

# button_conditioner

Synchronizes, debounces and edge-detects one mechanical push-button input so the counter/7-segment display stage downstream sees exactly one clean event per physical press. It sits between the board pin and the digit-increment logic. It provides two outputs: a clean active-low level, whose negedge is safe to use, and single-cycle press/release strobes for synchronous consumers. Optional hold-to-repeat generates additional press strobes while the button is held.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz). Minimum value is 2.
- REPEAT_DELAY, 25000000: cycles from the accepted press to the first repeat strobe. Minimum value is 2.
- REPEAT_PERIOD, 10000000: cycles between subsequent repeat strobes. Minimum value is 2.
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- buttonRaw  input  1  asynchronous pin, active-low (0 = pressed).
- buttonLevel  output  1  debounced level, active-low, registered.
- pressPulse  output  1  one-cycle high strobe on an accepted press, or on a repeat.
- releasePulse  output  1  one-cycle high strobe on an accepted release.

## Operation
- **Synchronizer:** two flops, sync1 then sync2; both reset to 1.
- **Debounce counter:** width is $clog2(DEBOUNCE_CYCLES).
  - Clears whenever sync2 == buttonLevel.
  - Increments each cycle while sync2 != buttonLevel.
  - At the edge where the count == DEBOUNCE_CYCLES-1 and the mismatch persists, buttonLevel <= sync2 and the count clears.
- **Bounce rejection:** any mismatch run shorter than DEBOUNCE_CYCLES restarts the count. It produces no output change and no strobe.
- **FSM states:** RELEASED (reset state), PRESSED, REPEATING.
  - RELEASED -> PRESSED on accepted fall of buttonLevel; pressPulse=1 for that cycle.
  - PRESSED/REPEATING -> RELEASED on accepted rise; releasePulse=1 for that cycle.
  - PRESSED -> REPEATING occurs only with AUTO_REPEAT_EN (see Configuration).
- **Repeat counter:** width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)). It clears on entry to PRESSED and on each repeat strobe.
- **Simultaneous events:** a release accepted in the same cycle a repeat would fire wins. releasePulse=1, pressPulse=0, and the repeat counter clears.
- **pressPulse and releasePulse** are never high in the same cycle.
- **Reset mid-operation:**
  - Reset returns all state to the reset values, whatever the current state.
  - If buttonRaw is still low after reset deasserts, the block treats it as a new press. It requires the full debounce and then emits pressPulse.

## Timing
- **Reset values:** buttonLevel=1, pressPulse=0, releasePulse=0, sync1=sync2=1, both counters=0, state=RELEASED.
- **Latency:** with buttonRaw changed and held before edge 0:
  - sync1 updates at edge 0.
  - sync2 updates at edge 1.
  - buttonLevel and the strobe update at edge DEBOUNCE_CYCLES+1.
  - Total: DEBOUNCE_CYCLES+2 cycles from pin to output.
- **Strobe alignment:** each strobe is registered and coincides with the first cycle of the new buttonLevel value. Each strobe lasts exactly one cycle.
- **Repeat strobes:**
  - The first repeat is REPEAT_DELAY cycles after the press strobe.
  - Each following repeat is REPEAT_PERIOD cycles after the previous one.

## Configuration
- **AUTO_REPEAT_EN defined:**
  - In PRESSED, the repeat counter runs. At count REPEAT_DELAY-1, the block emits pressPulse, clears the counter and enters REPEATING.
  - In REPEATING, at count REPEAT_PERIOD-1, the block emits pressPulse and clears the counter.
  - Repeats continue until the release is accepted.
- **AUTO_REPEAT_EN undefined:**
  - The repeat counter and the REPEATING state are not compiled in.
  - PRESSED holds until the release is accepted.
  - Exactly one pressPulse per press.
  - REPEAT_* parameters are accepted but ignored.
  - Port list is identical in both builds.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.

- **Reset with button held:** reset=1 for 3 cycles with buttonRaw=0 -> buttonLevel=1 and no strobes during reset. After deassert, buttonLevel=0 and pressPulse=1 exactly 6 cycles later, for 1 cycle.
- **Clean press and release, macro off:** buttonRaw 1->0 held 30 cycles, then 1 -> exactly one pressPulse at +6 and buttonLevel=0 from +6. releasePulse is a single cycle at +6 after the rise. No other strobes.
- **Bounce rejection:** buttonRaw sequence low 3, high 1, low 3, high 2, with the phases contiguous, then stays high -> buttonLevel stays 1 and no strobes. A subsequent low held for 6+ cycles is accepted at +6 from its start.
- **Auto-repeat, macro on:** press held 40 cycles after the press strobe -> pressPulse at strobe+0, +10, +15, +20, +25, +30, +35, +40, i.e. 8 pulses. The release produces 1 releasePulse and no further pressPulse.
- **Release collides with a due repeat, macro on:** time the accepted release on the cycle a repeat is due -> releasePulse=1, pressPulse=0 that cycle, and the state is RELEASED afterwards.
- **Reset mid-repeat, macro on:** assert reset for 1 cycle while in REPEATING with buttonRaw held low -> outputs return to reset values for that cycle. A fresh pressPulse follows 6 cycles after reset deasserts, and the first repeat follows 10 cycles after that.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes, debounces and edge-detects one active-low
// push-button so downstream logic sees one clean event per physical press.
// Outputs a registered debounced level plus one-cycle press/release strobes.
// Optional feature macro: AUTO_REPEAT_EN adds hold-to-repeat press strobes
// (REPEATING state and repeat counter); without it the REPEAT_* parameters
// are accepted but have no effect. The port list is the same in both builds.
`timescale 1ns/1ps

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clock,
  input  logic reset,
  input  logic buttonRaw,
  output logic buttonLevel,
  output logic pressPulse,
  output logic releasePulse
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Parameter values below 2 break the counter widths and terminal counts.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
  end

`ifdef AUTO_REPEAT_EN
  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    PRESSED   = 2'd1,
    REPEATING = 2'd2
  } state_t;

  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = $clog2(RP_MAX);
  localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

  logic [RP_W-1:0] repeat_count;
  logic [RP_W-1:0] repeat_next;
`else
  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } state_t;
`endif

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] debounce_count;
  logic            mismatch;
  logic            accept;
  logic            accept_fall;
  logic            accept_rise;
  state_t          state;
  state_t          next_state;
  logic            press_next;
  logic            release_next;

  // Two-flop synchronizer bringing the asynchronous pin into the clock domain.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= buttonRaw;
      sync2 <= sync1;
    end
  end

  assign mismatch    = (sync2 != buttonLevel);
  assign accept      = mismatch && (debounce_count == DB_LAST);
  assign accept_fall = accept && !sync2;
  assign accept_rise = accept && sync2;

  // Debounce: count consecutive mismatch cycles and adopt the new level only
  // after DEBOUNCE_CYCLES of them; any agreement in between restarts the run.
  always_ff @(posedge clock) begin
    if (reset) begin
      debounce_count <= '0;
      buttonLevel    <= 1'b1;
    end else if (!mismatch) begin
      debounce_count <= '0;
    end else if (accept) begin
      debounce_count <= '0;
      buttonLevel    <= sync2;
    end else begin
      debounce_count <= debounce_count + 1'b1;
    end
  end

  // Next-state and strobe decode; a release always beats a repeat due the same cycle.
  always_comb begin
    next_state   = state;
    press_next   = 1'b0;
    release_next = 1'b0;
`ifdef AUTO_REPEAT_EN
    repeat_next  = '0;
`endif
    case (state)
      RELEASED: begin
        if (accept_fall) begin
          next_state = PRESSED;
          press_next = 1'b1;
        end
      end
      PRESSED: begin
        if (accept_rise) begin
          next_state   = RELEASED;
          release_next = 1'b1;
`ifdef AUTO_REPEAT_EN
        end else if (repeat_count == DELAY_LAST) begin
          next_state = REPEATING;
          press_next = 1'b1;
        end else begin
          repeat_next = repeat_count + 1'b1;
`endif
        end
      end
`ifdef AUTO_REPEAT_EN
      REPEATING: begin
        if (accept_rise) begin
          next_state   = RELEASED;
          release_next = 1'b1;
        end else if (repeat_count == PERIOD_LAST) begin
          press_next = 1'b1;
        end else begin
          repeat_next = repeat_count + 1'b1;
        end
      end
`endif
      default: begin
        next_state = RELEASED;
      end
    endcase
  end

  // State, repeat counter and registered strobes, aligned with the new buttonLevel.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= RELEASED;
      pressPulse   <= 1'b0;
      releasePulse <= 1'b0;
`ifdef AUTO_REPEAT_EN
      repeat_count <= '0;
`endif
    end else begin
      state        <= next_state;
      pressPulse   <= press_next;
      releasePulse <= release_next;
`ifdef AUTO_REPEAT_EN
      repeat_count <= repeat_next;
`endif
    end
  end

endmodule
